// File: rtl/keypad_scanner_pkg.sv
// ============================================================================
//  Module   : keypad_pkg
//  Brief    : Shared types, key map and default timing for the keypad scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int DEFAULT_ROW_CYCLES      = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 200;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    // Indexed [row][col], col0 is the leftmost keypad column.
    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [1:0] lowest_low_col(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!c[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
// ============================================================================
//  Module   : keypad_if
//  Brief    : Keypad matrix and decoded-key signal bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_if;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (output cols, input rows, key, key_valid, key_held);
    modport slave  (input cols, output rows, key, key_valid, key_held);
endinterface

`default_nettype wire

// File: rtl/keypad_scanner_sync_2ff.sv
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Two-flop synchronizer with configurable width and reset value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module   : keypad_scanner
//  Brief    : 4x4 keypad row scanner with press/release debounce, no rollover.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES      = DEFAULT_ROW_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic clk,
    input  wire logic reset,
    keypad_if.slave   bus
);

    localparam int CNT_MAX = (ROW_CYCLES > DEBOUNCE_CYCLES) ? ROW_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       cs;
    state_t           r_state,     w_state_next;
    logic [1:0]       r_row,       w_row_next;
    logic [1:0]       r_col,       w_col_next;
    logic [CNT_W-1:0] r_cnt,       w_cnt_next;
    logic [3:0]       r_key,       w_key_next;
    logic             r_key_valid, w_key_valid_next;
    logic             w_col_low;

    sync_2ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1111)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.cols),
        .q     (cs)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SCAN;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_cnt       <= '0;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            r_cnt       <= w_cnt_next;
            r_key       <= w_key_next;
            r_key_valid <= w_key_valid_next;
        end
    end

    assign w_col_low = ~cs[r_col];

    always_comb begin
        w_state_next     = r_state;
        w_row_next       = r_row;
        w_col_next       = r_col;
        w_cnt_next       = r_cnt;
        w_key_next       = r_key;
        w_key_valid_next = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_cnt == ROW_LAST) begin
                    w_cnt_next = '0;
                    if (cs != 4'b1111) begin
                        w_col_next   = lowest_low_col(cs);
                        w_state_next = ST_DB_PRESS;
                    end else begin
                        w_row_next = r_row + 2'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DB_PRESS: begin
                if (!w_col_low) begin
                    // Bounce: rescan the same row from the start.
                    w_state_next = ST_SCAN;
                    w_cnt_next   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_next     = ST_HELD;
                    w_cnt_next       = '0;
                    w_key_next       = KEY_MAP[r_row][r_col];
                    w_key_valid_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_col_low) begin
                    w_state_next = ST_DB_RELEASE;
                    w_cnt_next   = '0;
                end
            end
            ST_DB_RELEASE: begin
                if (w_col_low) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_next = ST_SCAN;
                    w_row_next   = r_row + 2'd1;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SCAN;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.rows      = ~(4'b0001 << r_row);
    assign bus.key       = r_key;
    assign bus.key_valid = r_key_valid;
    assign bus.key_held  = (r_state == ST_HELD) || (r_state == ST_DB_RELEASE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
//  Module   : tb_keypad_scanner
//  Brief    : Self-checking bench with a behavioural 4x4 keypad matrix model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] key;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pm [4];
    int         checks = 0;
    int         errors = 0;
    int         pushed = 0;
    int         valid_seen = 0;
    logic [3:0] last_key = 4'h0;
    logic [3:0] exp_q [$];
    vec_t       vecs [8];

    keypad_if bus ();

    keypad_scanner #(
        .ROW_CYCLES      (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pressed switch shorts the driven-low row onto its column.
    assign bus.cols = ~(({4{~bus.rows[0]}} & pm[0]) | ({4{~bus.rows[1]}} & pm[1]) |
                        ({4{~bus.rows[2]}} & pm[2]) | ({4{~bus.rows[3]}} & pm[3]));

    always @(negedge clk) begin
        if (bus.key_valid) begin
            valid_seen++;
            last_key = bus.key;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] k);
        exp_q.push_back(k);
        pushed++;
    endtask

    task automatic expect_valid(input string name, input int bound);
        int         base;
        int         t;
        logic [3:0] e;
        base = valid_seen;
        t = 0;
        while (valid_seen == base && t < bound) begin
            cyc(1);
            t++;
        end
        e = 4'hx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (valid_seen == base) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_key_valid required=key_valid", name);
        end else begin
            chk({name, "_key"}, last_key, e);
            chk({name, "_held"}, bus.key_held, 1'b1);
            cyc(1);
            chk({name, "_pulse_width"}, bus.key_valid, 1'b0);
        end
    endtask

    task automatic wait_held_low(input string name, input int bound);
        int t;
        t = 0;
        while (bus.key_held && t < bound) begin
            cyc(1);
            t++;
        end
        chk(name, bus.key_held, 1'b0);
    endtask

    initial begin
        int         base;
        logic [3:0] er;

        vecs[0] = '{2'd2, 2'd1, 4'h8};
        vecs[1] = '{2'd1, 2'd1, 4'h5};
        vecs[2] = '{2'd0, 2'd3, 4'hA};
        vecs[3] = '{2'd3, 2'd0, 4'hE};
        vecs[4] = '{2'd3, 2'd2, 4'hF};
        vecs[5] = '{2'd3, 2'd1, 4'h0};
        vecs[6] = '{2'd3, 2'd3, 4'hD};
        vecs[7] = '{2'd0, 2'd0, 4'h1};
        for (int r = 0; r < 4; r++) pm[r] = 4'b0000;

        // Reset state
        cyc(3);
        chk("rst_rows", bus.rows, 4'b1110);
        chk("rst_key", bus.key, 4'h0);
        chk("rst_valid", bus.key_valid, 1'b0);
        chk("rst_held", bus.key_held, 1'b0);

        // Idle scan: each row low for four cycles in order
        reset = 1'b1;
        chk("scan_rows_k0", bus.rows, 4'b1110);
        for (int k = 1; k < 32; k++) begin
            cyc(1);
            er = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_rows", bus.rows, er);
        end
        chk("scan_no_valid", valid_seen, 0);

        // Clean presses across the key map
        for (int i = 0; i < 8; i++) begin
            push_exp(vecs[i].key);
            pm[vecs[i].row] = 4'b0001 << vecs[i].col;
            expect_valid("press", 200);
            pm[vecs[i].row] = 4'b0000;
            cyc(4);
            chk("held_during_release_db", bus.key_held, 1'b1);
            wait_held_low("release", 100);
            chk("key_kept", bus.key, vecs[i].key);
            cyc(5);
        end

        // Bouncing "5" never debounces, then settles
        base = valid_seen;
        for (int i = 0; i < 20; i++) begin
            pm[1] = (((i / 3) % 2) == 0) ? 4'b0010 : 4'b0000;
            cyc(1);
        end
        chk("bounce_no_valid", valid_seen, base);
        pm[1] = 4'b0010;
        push_exp(4'h5);
        expect_valid("bounce_settled", 200);
        pm[1] = 4'b0000;
        wait_held_low("bounce_release", 100);

        // Short release glitch on "A" stays held
        push_exp(4'hA);
        pm[0] = 4'b1000;
        expect_valid("glitch_press", 200);
        base = valid_seen;
        pm[0] = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) pm[0] = 4'b1000;
            cyc(1);
            chk("glitch_held", bus.key_held, 1'b1);
        end
        chk("glitch_no_valid", valid_seen, base);
        pm[0] = 4'b0000;
        wait_held_low("glitch_release", 100);

        // Second key ignored while first is held, found after release
        push_exp(4'h1);
        pm[0] = 4'b0001;
        expect_valid("two_first", 200);
        base = valid_seen;
        pm[2] = 4'b1000;
        cyc(30);
        chk("two_no_rollover", valid_seen, base);
        chk("two_key_still_1", bus.key, 4'h1);
        push_exp(4'hC);
        pm[0] = 4'b0000;
        expect_valid("two_second", 200);
        pm[2] = 4'b0000;
        wait_held_low("two_release", 100);

        // Reset during DB_PRESS of "F"
        pm[3] = 4'b0100;
        begin
            int t;
            t = 0;
            while (bus.rows != 4'b0111 && t < 40) begin
                cyc(1);
                t++;
            end
        end
        chk("mid_reach_row3", bus.rows, 4'b0111);
        cyc(6);
        chk("mid_in_db_press", bus.rows, 4'b0111);
        base = valid_seen;
        reset = 1'b0;
        #1;
        chk("mid_rst_rows", bus.rows, 4'b1110);
        chk("mid_rst_key", bus.key, 4'h0);
        chk("mid_rst_valid", bus.key_valid, 1'b0);
        chk("mid_rst_held", bus.key_held, 1'b0);
        cyc(3);
        reset = 1'b1;
        chk("mid_restart_row0", bus.rows, 4'b1110);
        cyc(16);
        chk("mid_no_early_valid", valid_seen, base);
        chk("mid_key_zero", bus.key, 4'h0);
        push_exp(4'hF);
        expect_valid("mid_repress", 200);
        pm[3] = 4'b0000;
        wait_held_low("mid_release", 100);

        cyc(10);
        chk("queue_empty", exp_q.size(), 0);
        chk("valid_total", valid_seen, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
